// File: rtl/cache_arb_pkg.sv
// Shared constants and helpers for the replacement-controller arbiter.
// Holds FSM encodings, request-type constants and width/encoding functions.
package cache_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOOKUP  = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    localparam logic REQ_UPDATE = 1'b0;
    localparam logic REQ_VICTIM = 1'b1;

    // Never returns less than 1 so single-entry vectors still get a legal width.
    function automatic int log2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic logic [31:0] onehot_to_bin(input logic [31:0] onehot);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) begin
                result = result | 32'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/replacement_arbiter_if.sv
// Requester, response and controller-facing signals of the replacement arbiter.
// The master side is the requesters plus the controller; the slave side is the arbiter.
interface replacement_arbiter_if
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int NUMBER_OF_WAYS = 4,
    parameter int INDEX_BITS     = 8
);
    localparam int WAY_BITS = log2(NUMBER_OF_WAYS);

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_victim;
    logic [NUM_REQ*INDEX_BITS-1:0]     req_index;
    logic [NUM_REQ*WAY_BITS-1:0]       req_way;
    logic [NUM_REQ*NUMBER_OF_WAYS-1:0] req_ways_in_use;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0]                resp_valid;
    logic [NUMBER_OF_WAYS-1:0]         resp_way;
    logic [INDEX_BITS-1:0]             rc_current_index;
    logic [WAY_BITS-1:0]               rc_current_access;
    logic                              rc_access_valid;
    logic [NUMBER_OF_WAYS-1:0]         rc_ways_in_use;
    logic [NUMBER_OF_WAYS-1:0]         rc_selected_way;

    modport master (
        output req_valid, req_victim, req_index, req_way, req_ways_in_use, rc_selected_way,
        input  req_ready, resp_valid, resp_way,
        input  rc_current_index, rc_current_access, rc_access_valid, rc_ways_in_use
    );

    modport slave (
        input  req_valid, req_victim, req_index, req_way, req_ways_in_use, rc_selected_way,
        output req_ready, resp_valid, resp_way,
        output rc_current_index, rc_current_access, rc_access_valid, rc_ways_in_use
    );

endinterface

// File: rtl/replacement_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first requester strictly after the pointer wins.
// The pointer register is owned by the instantiating module.
module rr_arbiter
    import cache_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = log2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= 32'(NUM_REQ); k++) begin
            cand = PTR_W'((32'(ptr_i) + k) % 32'(NUM_REQ));
            if (en_i && !found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/replacement_arbiter.sv
// Shares one replacement controller between several cache pipelines: arbitrates,
// sequences controller updates/lookups and returns the chosen victim way.
module replacement_arbiter
    import cache_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 2,
    parameter  int NUMBER_OF_WAYS = 4,
    parameter  int INDEX_BITS     = 8,
    localparam int WAY_BITS       = log2(NUMBER_OF_WAYS),
    localparam int PTR_W          = log2(NUM_REQ)
) (
    input logic                  clock,
    input logic                  reset,
    replacement_arbiter_if.slave bus
);

    logic [1:0]                state_q, state_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [NUM_REQ-1:0]        gnt_q, gnt_d;
    logic [INDEX_BITS-1:0]     rc_index_q, rc_index_d;
    logic [WAY_BITS-1:0]       rc_access_q, rc_access_d;
    logic                      rc_valid_q, rc_valid_d;
    logic [NUMBER_OF_WAYS-1:0] rc_ways_q, rc_ways_d;
    logic [NUM_REQ-1:0]        resp_valid_q, resp_valid_d;
    logic [NUMBER_OF_WAYS-1:0] resp_way_q, resp_way_d;

    logic [NUM_REQ-1:0]        grant;
    logic                      arb_en;
    logic                      xfer;
    logic [PTR_W-1:0]          gnt_idx;
    logic                      sel_victim;
    logic [INDEX_BITS-1:0]     sel_index;
    logic [WAY_BITS-1:0]       sel_way;
    logic [NUMBER_OF_WAYS-1:0] sel_mask;

    // Grants only in IDLE and never while reset is held low.
    assign arb_en = reset && (state_q == ST_IDLE);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .en_i    (arb_en),
        .grant_o (grant)
    );

    assign bus.req_ready         = grant;
    assign bus.resp_valid        = resp_valid_q;
    assign bus.resp_way          = resp_way_q;
    assign bus.rc_current_index  = rc_index_q;
    assign bus.rc_current_access = rc_access_q;
    assign bus.rc_access_valid   = rc_valid_q;
    assign bus.rc_ways_in_use    = rc_ways_q;

    always_comb begin
        gnt_idx    = '0;
        sel_victim = REQ_UPDATE;
        sel_index  = '0;
        sel_way    = '0;
        sel_mask   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx    = PTR_W'(i);
                sel_victim = bus.req_victim[i];
                sel_index  = bus.req_index[i*INDEX_BITS +: INDEX_BITS];
                sel_way    = bus.req_way[i*WAY_BITS +: WAY_BITS];
                sel_mask   = bus.req_ways_in_use[i*NUMBER_OF_WAYS +: NUMBER_OF_WAYS];
            end
        end
        xfer = |(grant & bus.req_valid);
    end

    // The controller answer is captured at the end of LOOKUP so it appears,
    // together with the MRU update of the victim, during RESPOND.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        rc_index_d   = rc_index_q;
        rc_access_d  = rc_access_q;
        rc_ways_d    = rc_ways_q;
        resp_way_d   = resp_way_q;
        rc_valid_d   = 1'b0;
        resp_valid_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    ptr_d      = gnt_idx;
                    gnt_d      = grant;
                    rc_index_d = sel_index;
                    if (sel_victim == REQ_VICTIM) begin
                        rc_ways_d = sel_mask;
                        state_d   = ST_LOOKUP;
                    end else begin
                        rc_access_d = sel_way;
                        rc_valid_d  = 1'b1;
                    end
                end
            end
            ST_LOOKUP: begin
                state_d      = ST_RESPOND;
                resp_valid_d = gnt_q;
                resp_way_d   = bus.rc_selected_way;
                if (|bus.rc_selected_way) begin
                    rc_valid_d  = 1'b1;
                    rc_access_d = WAY_BITS'(onehot_to_bin(32'(bus.rc_selected_way)));
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= PTR_W'(NUM_REQ - 1);
            gnt_q        <= '0;
            rc_index_q   <= '0;
            rc_access_q  <= '0;
            rc_valid_q   <= 1'b0;
            rc_ways_q    <= '0;
            resp_valid_q <= '0;
            resp_way_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            rc_index_q   <= rc_index_d;
            rc_access_q  <= rc_access_d;
            rc_valid_q   <= rc_valid_d;
            rc_ways_q    <= rc_ways_d;
            resp_valid_q <= resp_valid_d;
            resp_way_q   <= resp_way_d;
        end
    end

endmodule

// File: tb/tb_replacement_arbiter.sv
// Self-checking bench for replacement_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of arbitration and lookup timing.
module tb_replacement_arbiter;
    import cache_arb_pkg::*;

    localparam int NUM_REQ        = 2;
    localparam int NUMBER_OF_WAYS = 4;
    localparam int INDEX_BITS     = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checkCount = 0;
    int   errorCount = 0;

    replacement_arbiter_if #(
        .NUM_REQ(NUM_REQ), .NUMBER_OF_WAYS(NUMBER_OF_WAYS), .INDEX_BITS(INDEX_BITS)
    ) bus ();

    replacement_arbiter #(
        .NUM_REQ(NUM_REQ), .NUMBER_OF_WAYS(NUMBER_OF_WAYS), .INDEX_BITS(INDEX_BITS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Controller stand-in: scan the mask starting at way (index>>3)%4.
    function automatic int ctrlWay(input logic [7:0] idx, input logic [3:0] mask);
        int start;
        int w;
        start = (int'(idx) >> 3) % 4;
        for (int k = 0; k < 4; k++) begin
            w = (start + k) % 4;
            if (mask[w]) return w;
        end
        return -1;
    endfunction

    function automatic logic [3:0] ctrlOneHot(input logic [7:0] idx, input logic [3:0] mask);
        int w;
        w = ctrlWay(idx, mask);
        return (w < 0) ? 4'b0000 : 4'(1 << w);
    endfunction

    assign bus.rc_selected_way = ctrlOneHot(bus.rc_current_index, bus.rc_ways_in_use);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setReq(input int r, input logic v, input logic vic, input logic [7:0] idx,
                          input logic [1:0] way, input logic [3:0] mask);
        bus.req_valid[r]                 = v;
        bus.req_victim[r]                = vic;
        bus.req_index[r*8 +: 8]          = idx;
        bus.req_way[r*2 +: 2]            = way;
        bus.req_ways_in_use[r*4 +: 4]    = mask;
    endtask

    task automatic clearReqs();
        bus.req_valid       = '0;
        bus.req_victim      = '0;
        bus.req_index       = '0;
        bus.req_way         = '0;
        bus.req_ways_in_use = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        setReq(0, 1'b1, REQ_UPDATE, 8'h33, 2'd1, 4'hF);
        setReq(1, 1'b1, REQ_VICTIM, 8'h44, 2'd2, 4'hF);
        repeat (3) tick();
        checkCount++; if (bus.req_ready !== 2'b00) begin errorCount++; $display("[TB] FAIL reset_ready: got %b expected 00", bus.req_ready); end
        checkCount++; if (bus.resp_valid !== 2'b00) begin errorCount++; $display("[TB] FAIL reset_resp_valid: got %b expected 00", bus.resp_valid); end
        checkCount++; if (bus.rc_access_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_access_valid: got %b expected 0", bus.rc_access_valid); end
        checkCount++; if (bus.rc_current_index !== 8'h00) begin errorCount++; $display("[TB] FAIL reset_index: got %h expected 00", bus.rc_current_index); end
        checkCount++; if (bus.resp_way !== 4'b0000) begin errorCount++; $display("[TB] FAIL reset_resp_way: got %b expected 0000", bus.resp_way); end
        clearReqs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_update();
        setReq(0, 1'b1, REQ_UPDATE, 8'h05, 2'd2, 4'h0);
        #1;
        checkCount++; if (bus.req_ready !== 2'b01) begin errorCount++; $display("[TB] FAIL update_ready: got %b expected 01", bus.req_ready); end
        tick();
        clearReqs();
        checkCount++; if (bus.rc_access_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL update_access_valid: got %b expected 1", bus.rc_access_valid); end
        checkCount++; if (bus.rc_current_index !== 8'h05) begin errorCount++; $display("[TB] FAIL update_index: got %h expected 05", bus.rc_current_index); end
        checkCount++; if (bus.rc_current_access !== 2'd2) begin errorCount++; $display("[TB] FAIL update_access: got %0d expected 2", bus.rc_current_access); end
        tick();
        checkCount++; if (bus.rc_access_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL update_access_drop: got %b expected 0", bus.rc_access_valid); end
    endtask

    task automatic test_victim_lookup();
        setReq(1, 1'b1, REQ_VICTIM, 8'h10, 2'd0, 4'b1111);
        #1;
        checkCount++; if (bus.req_ready !== 2'b10) begin errorCount++; $display("[TB] FAIL victim_ready: got %b expected 10", bus.req_ready); end
        tick();
        bus.req_valid[1] = 1'b0;
        setReq(0, 1'b1, REQ_UPDATE, 8'h21, 2'd1, 4'h0);
        #1;
        checkCount++; if (bus.rc_current_index !== 8'h10) begin errorCount++; $display("[TB] FAIL lookup_index: got %h expected 10", bus.rc_current_index); end
        checkCount++; if (bus.rc_ways_in_use !== 4'b1111) begin errorCount++; $display("[TB] FAIL lookup_mask: got %b expected 1111", bus.rc_ways_in_use); end
        checkCount++; if (bus.rc_access_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL lookup_access_valid: got %b expected 0", bus.rc_access_valid); end
        checkCount++; if (bus.req_ready !== 2'b00) begin errorCount++; $display("[TB] FAIL lookup_ready: got %b expected 00", bus.req_ready); end
        tick();
        checkCount++; if (bus.resp_valid !== 2'b10) begin errorCount++; $display("[TB] FAIL respond_valid: got %b expected 10", bus.resp_valid); end
        checkCount++; if (bus.resp_way !== 4'b0100) begin errorCount++; $display("[TB] FAIL respond_way: got %b expected 0100", bus.resp_way); end
        checkCount++; if (bus.rc_access_valid !== 1'b1) begin errorCount++; $display("[TB] FAIL respond_access_valid: got %b expected 1", bus.rc_access_valid); end
        checkCount++; if (bus.rc_current_access !== 2'd2) begin errorCount++; $display("[TB] FAIL respond_access: got %0d expected 2", bus.rc_current_access); end
        checkCount++; if (bus.req_ready !== 2'b00) begin errorCount++; $display("[TB] FAIL respond_ready: got %b expected 00", bus.req_ready); end
        tick();
        checkCount++; if (bus.req_ready !== 2'b01) begin errorCount++; $display("[TB] FAIL after_lookup_ready: got %b expected 01", bus.req_ready); end
        checkCount++; if (bus.resp_valid !== 2'b00) begin errorCount++; $display("[TB] FAIL after_lookup_resp: got %b expected 00", bus.resp_valid); end
        checkCount++; if (bus.rc_access_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL after_lookup_access_valid: got %b expected 0", bus.rc_access_valid); end
        tick();
        clearReqs();
        checkCount++; if (bus.rc_access_valid !== 1'b1 || bus.rc_current_index !== 8'h21 || bus.rc_current_access !== 2'd1) begin
            errorCount++; $display("[TB] FAIL follow_update: got v=%b idx=%h acc=%0d expected v=1 idx=21 acc=1", bus.rc_access_valid, bus.rc_current_index, bus.rc_current_access);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] expSeq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0] expIdx;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        setReq(0, 1'b1, REQ_UPDATE, 8'hA0, 2'd1, 4'h0);
        setReq(1, 1'b1, REQ_UPDATE, 8'hB1, 2'd3, 4'h0);
        #1;
        for (int i = 0; i < 4; i++) begin
            checkCount++; if (bus.req_ready !== expSeq[i]) begin errorCount++; $display("[TB] FAIL contention_ready[%0d]: got %b expected %b", i, bus.req_ready, expSeq[i]); end
            expIdx = (expSeq[i] == 2'b01) ? 8'hA0 : 8'hB1;
            tick();
            checkCount++; if (bus.rc_access_valid !== 1'b1 || bus.rc_current_index !== expIdx) begin
                errorCount++; $display("[TB] FAIL contention_update[%0d]: got v=%b idx=%h expected v=1 idx=%h", i, bus.rc_access_valid, bus.rc_current_index, expIdx);
            end
        end
        clearReqs();
        tick();
    endtask

    task automatic test_reset_mid_lookup();
        setReq(0, 1'b1, REQ_VICTIM, 8'h18, 2'd0, 4'hF);
        #1;
        checkCount++; if (bus.req_ready !== 2'b01) begin errorCount++; $display("[TB] FAIL midreset_grant: got %b expected 01", bus.req_ready); end
        tick();
        reset = 1'b0;
        setReq(0, 1'b1, REQ_UPDATE, 8'h55, 2'd1, 4'h0);
        setReq(1, 1'b1, REQ_UPDATE, 8'h66, 2'd2, 4'h0);
        #1;
        checkCount++; if (bus.req_ready !== 2'b00) begin errorCount++; $display("[TB] FAIL midreset_ready_low: got %b expected 00", bus.req_ready); end
        tick();
        clearReqs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkCount++; if (bus.resp_valid !== 2'b00 || bus.rc_access_valid !== 1'b0) begin
                errorCount++; $display("[TB] FAIL midreset_quiet[%0d]: got resp=%b av=%b expected resp=00 av=0", i, bus.resp_valid, bus.rc_access_valid);
            end
            tick();
        end
        setReq(0, 1'b1, REQ_UPDATE, 8'h55, 2'd1, 4'h0);
        setReq(1, 1'b1, REQ_UPDATE, 8'h66, 2'd2, 4'h0);
        #1;
        checkCount++; if (bus.req_ready !== 2'b01) begin errorCount++; $display("[TB] FAIL midreset_priority: got %b expected 01", bus.req_ready); end
        tick();
        clearReqs();
        checkCount++; if (bus.rc_access_valid !== 1'b1 || bus.rc_current_index !== 8'h55) begin
            errorCount++; $display("[TB] FAIL midreset_update: got v=%b idx=%h expected v=1 idx=55", bus.rc_access_valid, bus.rc_current_index);
        end
        tick();
    endtask

    task automatic test_zero_victim();
        setReq(0, 1'b1, REQ_VICTIM, 8'h40, 2'd0, 4'b0000);
        #1;
        checkCount++; if (bus.req_ready !== 2'b01) begin errorCount++; $display("[TB] FAIL zero_ready: got %b expected 01", bus.req_ready); end
        tick();
        clearReqs();
        tick();
        checkCount++; if (bus.resp_valid !== 2'b01) begin errorCount++; $display("[TB] FAIL zero_resp_valid: got %b expected 01", bus.resp_valid); end
        checkCount++; if (bus.resp_way !== 4'b0000) begin errorCount++; $display("[TB] FAIL zero_resp_way: got %b expected 0000", bus.resp_way); end
        checkCount++; if (bus.rc_access_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL zero_access_valid: got %b expected 0", bus.rc_access_valid); end
        tick();
    endtask

    // Transaction model: an accepted update blocks nothing, a lookup makes the block
    // busy for two more cycles and answers in the second; grants rotate after the last winner.
    task automatic test_random(input int cycles);
        logic       pend  [NUM_REQ];
        logic       pVic  [NUM_REQ];
        logic [7:0] pIdx  [NUM_REQ];
        logic [1:0] pWay  [NUM_REQ];
        logic [3:0] pMask [NUM_REQ];
        int         lastGrant, phase, nPhase, lkReq, w, g, cand;
        logic [7:0] lkIdx, expIdx, nIdx;
        logic [3:0] lkMask, expMask, nMask, expRespWay, nRespWay;
        logic [1:0] expAcc, nAcc, expRespV, nRespV, expG;
        logic       expAv, nAv;
        for (int r = 0; r < NUM_REQ; r++) begin
            pend[r] = 1'b0; pVic[r] = 1'b0; pIdx[r] = '0; pWay[r] = '0; pMask[r] = '0;
        end
        clearReqs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        lastGrant = NUM_REQ - 1;
        phase = 0; lkReq = 0; lkIdx = '0; lkMask = '0;
        expIdx = '0; expMask = '0; expRespWay = '0; expAcc = '0; expRespV = '0; expAv = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            checkCount++; if (bus.rc_access_valid !== expAv) begin errorCount++; $display("[TB] FAIL rand_access_valid@%0d: got %b expected %b", c, bus.rc_access_valid, expAv); end
            checkCount++; if (bus.rc_current_index !== expIdx) begin errorCount++; $display("[TB] FAIL rand_index@%0d: got %h expected %h", c, bus.rc_current_index, expIdx); end
            checkCount++; if (bus.rc_current_access !== expAcc) begin errorCount++; $display("[TB] FAIL rand_access@%0d: got %0d expected %0d", c, bus.rc_current_access, expAcc); end
            checkCount++; if (bus.rc_ways_in_use !== expMask) begin errorCount++; $display("[TB] FAIL rand_mask@%0d: got %b expected %b", c, bus.rc_ways_in_use, expMask); end
            checkCount++; if (bus.resp_valid !== expRespV) begin errorCount++; $display("[TB] FAIL rand_resp_valid@%0d: got %b expected %b", c, bus.resp_valid, expRespV); end
            if (expRespV != 2'b00) begin
                checkCount++; if (bus.resp_way !== expRespWay) begin errorCount++; $display("[TB] FAIL rand_resp_way@%0d: got %b expected %b", c, bus.resp_way, expRespWay); end
            end
            nAv = 1'b0; nRespV = '0; nRespWay = expRespWay; nIdx = expIdx; nAcc = expAcc; nMask = expMask; nPhase = 0;
            if (phase == 1) begin
                nPhase   = 2;
                w        = ctrlWay(lkIdx, lkMask);
                nRespV   = 2'(1 << lkReq);
                nRespWay = (w < 0) ? 4'b0000 : 4'(1 << w);
                if (w >= 0) begin
                    nAv  = 1'b1;
                    nAcc = 2'(w);
                end
            end
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
                    pend[r]  = 1'b1;
                    pVic[r]  = ($urandom_range(0, 2) == 0);
                    pIdx[r]  = 8'($urandom);
                    pWay[r]  = 2'($urandom);
                    pMask[r] = 4'($urandom_range(0, 15));
                end
                setReq(r, pend[r], pVic[r], pIdx[r], pWay[r], pMask[r]);
            end
            g = -1;
            if (phase == 0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    cand = (lastGrant + k) % NUM_REQ;
                    if (g < 0 && pend[cand]) g = cand;
                end
            end
            expG = (g >= 0) ? 2'(1 << g) : 2'b00;
            #1;
            checkCount++; if (bus.req_ready !== expG) begin errorCount++; $display("[TB] FAIL rand_ready@%0d: got %b expected %b", c, bus.req_ready, expG); end
            if (g >= 0) begin
                lastGrant = g;
                pend[g]   = 1'b0;
                nIdx      = pIdx[g];
                if (pVic[g]) begin
                    nMask = pMask[g]; nPhase = 1; lkReq = g; lkIdx = pIdx[g]; lkMask = pMask[g];
                end else begin
                    nAv = 1'b1; nAcc = pWay[g];
                end
            end
            expAv = nAv; expIdx = nIdx; expAcc = nAcc; expMask = nMask; expRespV = nRespV; expRespWay = nRespWay;
            phase = nPhase;
            tick();
        end
        clearReqs();
        tick();
    endtask

    initial begin
        clearReqs();
        reset = 1'b0;
        test_reset();
        test_single_update();
        test_victim_lookup();
        test_contention();
        test_reset_mid_lookup();
        test_zero_victim();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
